// File: rtl/apb_acc_pkg.sv
// Shared state encoding and register map for the APB accelerator master.
package apb_acc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  localparam logic [11:0] ACC_IN  = 12'h004;
  localparam logic [11:0] ACC_OUT = 12'h008;
  localparam logic [11:0] CONFIG  = 12'h00C;
  localparam logic [11:0] COUNTER = 12'h010;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-state counter with clear, enable and terminal-count flag.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
  parameter int unsigned TermCount = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned Width = (TermCount > 1) ? $clog2(TermCount) : 1;

  logic [Width-1:0] count_d, count_q;

  assign tc_o = (count_q == Width'(TermCount - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_acc_master.sv
// APB initiator: one SETUP/ACCESS transfer per valid/ready request, response held until taken.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_acc_master
  import apb_acc_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_state_e state_d, state_q;

  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q;
  logic                      pwrite_q;
  logic [31:0]               rsp_rdata_d, rsp_rdata_q;
  logic                      rsp_err_d, rsp_err_q;
  logic                      rsp_timeout_d, rsp_timeout_q;
  logic                      req_hs;
  logic                      rsp_load;
  logic                      cnt_clr;
  logic                      cnt_en;
  logic                      timeout_hit;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TermCount(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i (HCLK),
    .rst_ni(HRESETn),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (timeout_hit)
  );
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = cnt_clr ^ cnt_en ^ (TIMEOUT_CYCLES == 0);
`endif

  // Byte lanes are never used; the address is always word aligned on the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  always_comb begin
    state_d       = state_q;
    req_hs        = 1'b0;
    rsp_load      = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          req_hs  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_clr = 1'b1;
        state_d = StAccess;
      end
      StAccess: begin
        // A PREADY arriving on the terminal wait cycle still completes normally.
        if (PREADY) begin
          rsp_load    = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
          rsp_err_d   = PSLVERR;
          state_d     = StResp;
        end else if (timeout_hit) begin
          rsp_load      = 1'b1;
          rsp_rdata_d   = TIMEOUT_RDATA;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= StIdle;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        paddr_q  <= {req_addr[APB_ADDR_WIDTH-1:2], 2'b00};
        pwdata_q <= req_wdata;
        pwrite_q <= req_write;
      end
      if (rsp_load) begin
        rsp_rdata_q   <= rsp_rdata_d;
        rsp_err_q     <= rsp_err_d;
        rsp_timeout_q <= rsp_timeout_d;
      end
    end
  end

  // Gating with the reset keeps req_ready low while reset is asserted.
  assign req_ready   = (state_q == StIdle) && HRESETn;
  assign rsp_valid   = (state_q == StResp);
  assign busy        = (state_q != StIdle);
  assign PSEL        = (state_q == StSetup) || (state_q == StAccess);
  assign PENABLE     = (state_q == StAccess);
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_acc_master.sv
// Randomised scoreboard bench for apb_acc_master with a memory-backed APB slave model.
module tb_apb_acc_master;

  localparam int TMO = 8;

  logic        HCLK, HRESETn;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  apb_acc_master #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  typedef struct {
    logic [11:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic        tmo;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_mem[1024];
  logic [31:0] slave_mem[1024];
  int          n_tests = 0;
  int          n_fail = 0;
  int          hold_rsp = 0;
  bit          abort_xfer = 0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not expected or not seen (t=%0t)", name, $time);
  endtask

  // Queue the slave behaviour and expected response, then hand the request to the DUT.
  task automatic do_req(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                        input int waits, input logic err, input logic tmo, input bit rsp);
    plan_t p;
    exp_t  e;
    int    n;
    p.addr  = {addr[11:2], 2'b00};
    p.write = wr;
    p.wdata = wd;
    p.waits = waits;
    p.err   = err;
    p.tmo   = tmo;
    plan_q.push_back(p);
    if (rsp) begin
      e.tmo   = tmo;
      e.err   = err | tmo;
      e.rdata = tmo ? 32'hDEAD_DEAD : (wr ? 32'h0 : model_mem[addr[11:2]]);
      if (wr && !err && !tmo) model_mem[addr[11:2]] = wd;
      exp_q.push_back(e);
    end
    @(negedge HCLK);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge HCLK);
      n++;
    end
    if (!req_ready) begin
      fail_now("req_ready_wait");
      req_valid = 1'b0;
      return;
    end
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    check("setup_phase", 32'({PSEL, PENABLE}), 32'b10);
    req_valid = 1'b0;
    req_addr  = 12'($urandom);
    req_write = 1'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge HCLK);
      n++;
    end
    if (busy) fail_now("wait_idle");
  endtask

  // APB slave: follows the plan queue, checks bus timing and phase stability.
  initial begin
    plan_t cur;
    bit    active = 0;
    bit    done_chk = 0;
    int    wcnt = 0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge HCLK);
      PREADY  = 1'b0;
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
      if (done_chk) begin
        done_chk = 0;
        check("after_access", 32'({PSEL, PENABLE, rsp_valid}), 32'b001);
      end
      if (active) begin
        if (!PSEL) begin
          if (abort_xfer) begin
            abort_xfer = 0;
          end else if (cur.tmo) begin
            check("timeout_access_cycles", 32'(wcnt), 32'(TMO));
            check("timeout_rsp_valid", 32'(rsp_valid), 32'd1);
          end else begin
            fail_now("psel_dropped_early");
          end
          active = 0;
        end else begin
          check("access_penable", 32'(PENABLE), 32'd1);
          check("access_req_ready", 32'({req_ready, busy}), 32'b01);
          check("access_paddr", 32'(PADDR), 32'(cur.addr));
          check("access_pwrite", 32'(PWRITE), 32'(cur.write));
          check("access_pwdata", PWDATA, cur.wdata);
          if (wcnt == cur.waits) begin
            PREADY  = 1'b1;
            PSLVERR = cur.err;
            if (!cur.write) PRDATA = slave_mem[PADDR[11:2]];
            else if (!cur.err) slave_mem[PADDR[11:2]] = PWDATA;
            active   = 0;
            done_chk = 1;
          end else begin
            wcnt++;
          end
        end
      end else if (PSEL) begin
        check("setup_penable", 32'(PENABLE), 32'd0);
        if (plan_q.size() == 0) begin
          fail_now("unplanned_setup");
        end else begin
          cur = plan_q.pop_front();
          check("setup_paddr", 32'(PADDR), 32'(cur.addr));
          check("setup_pwrite", 32'(PWRITE), 32'(cur.write));
          check("setup_pwdata", PWDATA, cur.wdata);
          active = 1;
          wcnt   = 0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each new response and checks stability while held.
  initial begin
    exp_t cur_e;
    bit   in_rsp = 0;
    int   held = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge HCLK);
      if (!rsp_valid) begin
        in_rsp = 0;
      end else begin
        check("rsp_req_ready", 32'({req_ready, busy}), 32'b01);
        if (!in_rsp) begin
          held = 0;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_rsp");
            cur_e.rdata = rsp_rdata; cur_e.err = rsp_err; cur_e.tmo = rsp_timeout;
          end else begin
            cur_e = exp_q.pop_front();
          end
          in_rsp = 1;
        end
        check("rsp_rdata", rsp_rdata, cur_e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(cur_e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(cur_e.tmo));
      end
      if (rsp_valid && held < hold_rsp) begin
        rsp_ready = 1'b0;
        held++;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (rsp_valid && rsp_ready) begin
        in_rsp   = 0;
        hold_rsp = 0;
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = '0;
      slave_mem[i] = '0;
    end
    HRESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    repeat (3) @(negedge HCLK);
    check("reset_apb", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
    check("reset_paddr", 32'(PADDR), 32'd0);
    check("reset_pwdata", PWDATA, 32'd0);
    check("reset_rsp", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_ready_busy", 32'({req_ready, busy}), 32'd0);
    HRESETn = 1'b1;

    do_req(12'h004, 1'b1, 32'h0000_0010, 0, 1'b0, 1'b0, 1'b1);
    do_req(12'h010, 1'b1, 32'h0000_0003, 0, 1'b0, 1'b0, 1'b1);
    do_req(12'h010, 1'b0, 32'h1234_5678, 3, 1'b0, 1'b0, 1'b1);
    do_req(12'h008, 1'b0, 32'h0, 1, 1'b1, 1'b0, 1'b1);

    // Hold the next response off for five cycles while another request is pending.
    wait_idle();
    hold_rsp = 5;
    do_req(12'h00C, 1'b1, 32'hCAFE_0001, 0, 1'b0, 1'b0, 1'b1);
    do_req(12'h00F, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      do_req({6'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 2'($urandom)},
             1'($urandom), $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 4) == 0),
             1'b0, 1'b1);
    end

`ifdef APB_TIMEOUT_EN
    do_req(12'h010, 1'b0, 32'h0, 1000, 1'b0, 1'b1, 1'b1);
    do_req(12'h004, 1'b0, 32'h0, TMO - 1, 1'b0, 1'b0, 1'b1);
`endif

    // Reset in the middle of ACCESS abandons the transfer without a response.
    wait_idle();
    do_req(12'h008, 1'b0, 32'h0, 50, 1'b0, 1'b0, 1'b0);
    @(negedge HCLK);
    abort_xfer = 1;
    #2 HRESETn = 1'b0;
    #1 check("reset_mid_access", 32'({PSEL, PENABLE, rsp_valid, busy}), 32'd0);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    // Memory contents live in the slave, so they survive the master reset.
    do_req(12'h010, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
    do_req(12'h004, 1'b1, 32'h5555_AAAA, 2, 1'b0, 1'b0, 1'b1);
    do_req(12'h004, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b1);

    n = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0 || busy) && n < 2000) begin
      @(negedge HCLK);
      n++;
    end
    check("drain_responses", 32'(exp_q.size()), 32'd0);
    check("drain_transfers", 32'(plan_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
